// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// bus FSM state type and reset constants.
package clint_pkg;

  localparam logic [31:0] CLINT_MSIP        = 32'd0;
  localparam logic [31:0] CLINT_MTIMECMP_LO = 32'd1;
  localparam logic [31:0] CLINT_MTIMECMP_HI = 32'd2;
  localparam logic [31:0] CLINT_MTIME_LO    = 32'd3;
  localparam logic [31:0] CLINT_MTIME_HI    = 32'd4;
  localparam logic [31:0] CLINT_PRESCALE    = 32'd5;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Bus handshake: a request transfers when i_req_valid && o_req_ready on a
  // rising clk edge; a response transfers when o_rsp_valid && i_rsp_ready.
  // o_rsp_rdata/o_rsp_err are stable while o_rsp_valid is high.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_t;

  function automatic logic is_mapped(input logic [31:0] off);
    return off <= CLINT_PRESCALE;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaled tick source for mtime: a pulse every prescale+1 cycles, with a
// synchronous clear used when software rewrites the prescale value.
module clint_tick_gen
  import clint_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      clear,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] count;

  // The tick is combinational so mtime advances on the same edge the counter wraps.
  assign tick = (count == prescale);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Machine-level CLINT: 64-bit mtime/mtimecmp, MSIP bit and interrupt request
// lines, accessed through a two-state valid/ready peripheral responder.
module clint_timer
  import clint_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 3,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_timer_int_call,
  output logic                  o_software_int_call
);

  bus_state_t                state;
  logic [63:0]               mtime;
  logic [63:0]               mtimecmp;
  logic                      msip;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      tick;
  logic                      accept;
  logic                      wr_en;
  logic [31:0]               off;
  logic [31:0]               wdata;
  logic [31:0]               rd_data;

  assign off    = 32'(i_req_addr);
  assign wdata  = 32'(i_req_wdata);
  assign accept = (state == IDLE) && i_req_valid;
  assign wr_en  = accept && i_req_write;

  clint_tick_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_tick_gen (
    .clk      (clk),
    .arst     (arst),
    .prescale (prescale),
    .clear    (wr_en && (off == CLINT_PRESCALE)),
    .tick     (tick)
  );

  always_comb begin
    rd_data = '0;
    case (off)
      CLINT_MSIP:        rd_data = {31'd0, msip};
      CLINT_MTIMECMP_LO: rd_data = mtimecmp[31:0];
      CLINT_MTIMECMP_HI: rd_data = mtimecmp[63:32];
      CLINT_MTIME_LO:    rd_data = mtime[31:0];
      CLINT_MTIME_HI:    rd_data = mtime[63:32];
      CLINT_PRESCALE:    rd_data = 32'(prescale);
      default:           rd_data = '0;
    endcase
  end

  // A write to one half of mtime freezes the other half for that edge: no
  // tick and no carry, so software sees exactly what it wrote.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mtime <= '0;
    end else if (wr_en && (off == CLINT_MTIME_LO)) begin
      mtime[31:0] <= wdata;
    end else if (wr_en && (off == CLINT_MTIME_HI)) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mtimecmp <= MTIMECMP_RST;
      msip     <= 1'b0;
      prescale <= '0;
    end else if (wr_en) begin
      case (off)
        CLINT_MSIP:        msip            <= wdata[0];
        CLINT_MTIMECMP_LO: mtimecmp[31:0]  <= wdata;
        CLINT_MTIMECMP_HI: mtimecmp[63:32] <= wdata;
        CLINT_PRESCALE:    prescale        <= PRESCALE_WIDTH'(wdata);
        default:           ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      o_timer_int_call <= 1'b0;
    end else begin
      o_timer_int_call <= (mtime >= mtimecmp);
    end
  end

  assign o_software_int_call = msip;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            state       <= RESP;
            o_req_ready <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= i_req_write ? '0 : DATA_WIDTH'(rd_data);
            o_rsp_err   <= !is_mapped(off);
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state       <= IDLE;
            o_req_ready <= 1'b1;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one task per feature, expected values
// worked out by hand from the edge-by-edge timing of each transaction.
module tb_clint_timer;

  logic        clk;
  logic        arst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        timer_int;
  logic        sw_int;

  int checks   = 0;
  int failures = 0;

  logic sw_at_accept;
  logic tmr_at_accept;

  clint_timer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(3),
    .PRESCALE_WIDTH(8)
  ) dut (
    .clk                 (clk),
    .arst                (arst),
    .i_req_valid         (req_valid),
    .o_req_ready         (req_ready),
    .i_req_write         (req_write),
    .i_req_addr          (req_addr),
    .i_req_wdata         (req_wdata),
    .o_rsp_valid         (rsp_valid),
    .i_rsp_ready         (rsp_ready),
    .o_rsp_rdata         (rsp_rdata),
    .o_rsp_err           (rsp_err),
    .o_timer_int_call    (timer_int),
    .o_software_int_call (sw_int)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full transaction with rsp_ready held high. Starts and ends #1 after
  // a clock edge; the request is accepted on the first edge, retired on the next.
  task automatic bus_xfer(input logic wr, input logic [2:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int n;
    n = 0;
    while (!req_ready && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid     = 1'b0;
    sw_at_accept  = sw_int;
    tmr_at_accept = timer_int;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL xfer_rsp_valid addr=%0d got=%b want=1", addr, rsp_valid);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic        er;
    arst      = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    wait_cycles(3);
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, timer_int, sw_int} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b valid=%b rdata=%h err=%b tmr=%b sw=%b want 1 0 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, timer_int, sw_int);
    end
    arst = 1'b0;
    wait_cycles(10);
    bus_xfer(1'b0, 3'd3, 32'd0, rd, er);
    checks++;
    if (!(rd == 32'd10 || rd == 32'd11) || er !== 1'b0) begin
      failures++;
      $display("FAIL reset_mtime_lo got=%0d err=%b want=10 or 11 err=0", rd, er);
    end
    checks++;
    if (timer_int !== 1'b0) begin
      failures++;
      $display("FAIL reset_timer_int got=%b want=0", timer_int);
    end
    bus_xfer(1'b0, 3'd4, 32'd0, rd, er);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL reset_mtime_hi got=%h want=0", rd);
    end
    bus_xfer(1'b0, 3'd2, 32'd0, rd, er);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL reset_mtimecmp_hi got=%h want=ffffffff", rd);
    end
    bus_xfer(1'b0, 3'd6, 32'd0, rd, er);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_read6 got rdata=%h err=%b want 0 1", rd, er);
    end
    bus_xfer(1'b1, 3'd7, 32'hDEAD_BEEF, rd, er);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_write7 got rdata=%h err=%b want 0 1", rd, er);
    end
  endtask

  task automatic test_timer_int;
    logic [31:0] rd;
    logic        er;
    // mtime=0 after accept edge A, returns after A+1
    bus_xfer(1'b1, 3'd3, 32'd0, rd, er);
    bus_xfer(1'b1, 3'd2, 32'd0, rd, er);
    checks++;
    if (timer_int !== 1'b0) begin
      failures++;
      $display("FAIL timer_after_cmp_hi got=%b want=0", timer_int);
    end
    bus_xfer(1'b1, 3'd1, 32'h20, rd, er);
    // now after A+5; mtime hits 0x20 after A+32, request after A+33
    wait_cycles(27);
    checks++;
    if (timer_int !== 1'b0) begin
      failures++;
      $display("FAIL timer_before_match got=%b want=0", timer_int);
    end
    wait_cycles(1);
    checks++;
    if (timer_int !== 1'b1) begin
      failures++;
      $display("FAIL timer_rise got=%b want=1", timer_int);
    end
    wait_cycles(5);
    checks++;
    if (timer_int !== 1'b1) begin
      failures++;
      $display("FAIL timer_level_hold got=%b want=1", timer_int);
    end
    bus_xfer(1'b1, 3'd1, 32'hFFFF_FFFF, rd, er);
    checks++;
    if (tmr_at_accept !== 1'b1 || timer_int !== 1'b0) begin
      failures++;
      $display("FAIL timer_drop got at_accept=%b next=%b want 1 0", tmr_at_accept, timer_int);
    end
  endtask

  task automatic test_prescale;
    logic [31:0] rd;
    logic [31:0] v1;
    logic        er;
    bus_xfer(1'b1, 3'd5, 32'd3, rd, er);
    bus_xfer(1'b0, 3'd3, 32'd0, v1, er);
    wait_cycles(38);
    bus_xfer(1'b0, 3'd3, 32'd0, rd, er);
    checks++;
    if (rd - v1 !== 32'd10) begin
      failures++;
      $display("FAIL prescale_delta got=%0d want=10", rd - v1);
    end
    bus_xfer(1'b0, 3'd5, 32'd0, rd, er);
    checks++;
    if (rd !== 32'd3) begin
      failures++;
      $display("FAIL prescale_read got=%0d want=3", rd);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd;
    logic        er;
    // one tick every 256 cycles keeps the two half-writes tick-free
    bus_xfer(1'b1, 3'd5, 32'd255, rd, er);
    bus_xfer(1'b1, 3'd3, 32'hFFFF_FFFF, rd, er);
    bus_xfer(1'b1, 3'd4, 32'hFFFF_FFFF, rd, er);
    bus_xfer(1'b0, 3'd3, 32'd0, rd, er);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_pre_lo got=%h want=ffffffff", rd);
    end
    bus_xfer(1'b0, 3'd4, 32'd0, rd, er);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_pre_hi got=%h want=ffffffff", rd);
    end
    wait_cycles(250);
    bus_xfer(1'b0, 3'd3, 32'd0, rd, er);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL wrap_post_lo got=%h want=0", rd);
    end
    bus_xfer(1'b0, 3'd4, 32'd0, rd, er);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL wrap_post_hi got=%h want=0", rd);
    end
  endtask

  task automatic test_collision;
    logic [31:0] rd;
    logic        er;
    bus_xfer(1'b1, 3'd5, 32'd0, rd, er);
    // write lands on a tick edge Z+2; ticks at Z+3 then read sees pre-edge Z+4
    bus_xfer(1'b1, 3'd3, 32'h1234_5678, rd, er);
    bus_xfer(1'b0, 3'd3, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h1234_5679) begin
      failures++;
      $display("FAIL collision_lo got=%h want=12345679", rd);
    end
    bus_xfer(1'b0, 3'd4, 32'd0, rd, er);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL collision_lo_hi got=%h want=0", rd);
    end
    // LO=0x100 at C, 0x101 after C+1; HI write at C+2 freezes LO at 0x101
    bus_xfer(1'b1, 3'd3, 32'h100, rd, er);
    bus_xfer(1'b1, 3'd4, 32'd7, rd, er);
    bus_xfer(1'b0, 3'd3, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h102) begin
      failures++;
      $display("FAIL collision_hi_keeps_lo got=%h want=102", rd);
    end
    bus_xfer(1'b0, 3'd4, 32'd0, rd, er);
    checks++;
    if (rd !== 32'd7) begin
      failures++;
      $display("FAIL collision_hi got=%h want=7", rd);
    end
    bus_xfer(1'b1, 3'd4, 32'd0, rd, er);
  endtask

  task automatic test_msip;
    logic [31:0] rd;
    logic        er;
    checks++;
    if (sw_int !== 1'b0) begin
      failures++;
      $display("FAIL msip_initial got=%b want=0", sw_int);
    end
    bus_xfer(1'b1, 3'd0, 32'hFFFF_FFFF, rd, er);
    checks++;
    if (sw_at_accept !== 1'b1 || rd !== 32'd0 || er !== 1'b0) begin
      failures++;
      $display("FAIL msip_set got sw=%b rdata=%h err=%b want 1 0 0", sw_at_accept, rd, er);
    end
    bus_xfer(1'b0, 3'd0, 32'd0, rd, er);
    checks++;
    if (rd !== 32'h1) begin
      failures++;
      $display("FAIL msip_read got=%h want=1", rd);
    end
    bus_xfer(1'b1, 3'd0, 32'd0, rd, er);
    checks++;
    if (sw_at_accept !== 1'b0) begin
      failures++;
      $display("FAIL msip_clear got=%b want=0", sw_at_accept);
    end
  endtask

  task automatic test_hold_and_reset;
    logic [31:0] rd;
    logic        er;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 3'd1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_FFFF || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d got valid=%b rdata=%h ready=%b want 1 ffffffff 0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
      @(posedge clk);
      #1;
    end
    arst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_resp got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    arst      = 1'b0;
    rsp_ready = 1'b1;
    bus_xfer(1'b0, 3'd2, 32'd0, rd, er);
    checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL post_reset_cmp_hi got=%h want=ffffffff", rd);
    end
  endtask

  initial begin
    test_reset();
    test_timer_int();
    test_prescale();
    test_wrap();
    test_collision();
    test_msip();
    test_hold_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
